// File: rtl/ai_card_arbiter.sv
// -----------------------------------------------------------------------------
// ai_card_arbiter
//
// Purpose:
//   Shares one card delay/handoff stage between NREQ card producers. Each
//   producer delivers 8-bit card indices with single-cycle ready pulses. The
//   block holds one card per producer and hands them to the output one at a
//   time. It emits at most one tagged card every 2 cycles (grant cycle in IDLE,
//   emit cycle in EMIT).
//
// Configuration:
//   AI_ARB_FIXED_PRIO_EN  defined   -> always grant the lowest-index valid slot
//                                      (higher indices may starve, `last` is
//                                      held at its reset value)
//                         undefined -> round-robin starting after `last`
//
// Ports:
//   clk           in   1             clock
//   rst           in   1             reset, synchronous, active-high
//   req_card      in   NREQ*CARD_W   card from requester i at [i*CARD_W +: CARD_W]
//   req_rdy       in   NREQ          1-cycle valid pulse per requester
//   card_out      out  CARD_W        granted card, 0 when card_out_rdy=0
//   card_out_rdy  out  1             1-cycle valid pulse for card_out/card_src
//   card_src      out  SRC_W         requester index of card_out, 0 when idle
//   drop          out  NREQ          1-cycle pulse: card from requester i discarded
//   busy          out  1             any slot held or an emit in progress
// -----------------------------------------------------------------------------
module ai_card_arbiter #(
    parameter  int NREQ   = 4,
    parameter  int CARD_W = 8,
    localparam int SRC_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ*CARD_W-1:0]   req_card,
    input  logic [NREQ-1:0]          req_rdy,
    output logic [CARD_W-1:0]        card_out,
    output logic                     card_out_rdy,
    output logic [SRC_W-1:0]         card_src,
    output logic [NREQ-1:0]          drop,
    output logic                     busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [NREQ-1:0]     slot_v_q, slot_v_d;
    logic [CARD_W-1:0]   slot_card_q [NREQ];
    logic [CARD_W-1:0]   slot_card_d [NREQ];
    logic [CARD_W-1:0]   out_card_q, out_card_d;
    logic [SRC_W-1:0]    out_src_q, out_src_d;
    logic                out_rdy_q, out_rdy_d;
    logic [SRC_W-1:0]    last_q, last_d;

    logic                grant_found_s;
    logic [SRC_W-1:0]    grant_idx_s;
    logic [NREQ-1:0]     grant_vec_s;

    // Arbitration: locate the winning slot among the currently held cards.
    always_comb begin
        int cand;
        grant_found_s = 1'b0;
        grant_idx_s   = {SRC_W{1'b0}};
        cand          = 0;
`ifdef AI_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) begin
            cand = k;
            if (slot_v_q[cand] && !grant_found_s) begin
                grant_found_s = 1'b1;
                grant_idx_s   = SRC_W'(cand);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
`else
        // Scan last+1, last+2, ... so the most recent winner is checked last.
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_q) + k) % NREQ;
            if (slot_v_q[cand] && !grant_found_s) begin
                grant_found_s = 1'b1;
                grant_idx_s   = SRC_W'(cand);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
`endif
    end

    // One-hot grant, only meaningful while the FSM can accept a new card.
    always_comb begin
        grant_vec_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            grant_vec_s[i] = (state_q == ST_IDLE) && grant_found_s &&
                             (grant_idx_s == SRC_W'(i));
        end
    end

    // Slot capture: a granted slot is free again in the same cycle, so a new
    // card arriving on the grant cycle replaces it without being dropped.
    always_comb begin
        slot_v_d = slot_v_q;
        for (int i = 0; i < NREQ; i++) begin
            slot_card_d[i] = slot_card_q[i];
            if (req_rdy[i] && (!slot_v_q[i] || grant_vec_s[i])) begin
                slot_v_d[i]    = 1'b1;
                slot_card_d[i] = req_card[i*CARD_W +: CARD_W];
            end else if (grant_vec_s[i]) begin
                slot_v_d[i] = 1'b0;
            end else begin
                slot_v_d[i] = slot_v_q[i];
            end
        end
    end

    // FSM next state and output register values (outputs are zero in IDLE).
    always_comb begin
        state_d    = state_q;
        out_card_d = out_card_q;
        out_src_d  = out_src_q;
        out_rdy_d  = out_rdy_q;
        last_d     = last_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    state_d    = ST_EMIT;
                    out_card_d = slot_card_q[grant_idx_s];
                    out_src_d  = grant_idx_s;
                    out_rdy_d  = 1'b1;
`ifdef AI_ARB_FIXED_PRIO_EN
                    last_d     = last_q;
`else
                    last_d     = grant_idx_s;
`endif
                end else begin
                    state_d    = ST_IDLE;
                    out_card_d = {CARD_W{1'b0}};
                    out_src_d  = {SRC_W{1'b0}};
                    out_rdy_d  = 1'b0;
                end
            end
            ST_EMIT: begin
                state_d    = ST_IDLE;
                out_card_d = {CARD_W{1'b0}};
                out_src_d  = {SRC_W{1'b0}};
                out_rdy_d  = 1'b0;
            end
            default: begin
                state_d    = ST_IDLE;
                out_card_d = {CARD_W{1'b0}};
                out_src_d  = {SRC_W{1'b0}};
                out_rdy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; last points at NREQ-1 so
    // requester 0 has first priority after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            slot_v_q   <= {NREQ{1'b0}};
            out_card_q <= {CARD_W{1'b0}};
            out_src_q  <= {SRC_W{1'b0}};
            out_rdy_q  <= 1'b0;
            last_q     <= SRC_W'(NREQ - 1);
            for (int i = 0; i < NREQ; i++) begin
                slot_card_q[i] <= {CARD_W{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            slot_v_q   <= slot_v_d;
            out_card_q <= out_card_d;
            out_src_q  <= out_src_d;
            out_rdy_q  <= out_rdy_d;
            last_q     <= last_d;
            for (int i = 0; i < NREQ; i++) begin
                slot_card_q[i] <= slot_card_d[i];
            end
        end
    end

    // Drop: a new card hits a full slot that is not being drained this cycle.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            drop[i] = !rst && req_rdy[i] && slot_v_q[i] && !grant_vec_s[i];
        end
    end

    // Outputs come straight from registers, forced to zero while in reset.
    always_comb begin
        if (rst) begin
            card_out     = {CARD_W{1'b0}};
            card_src     = {SRC_W{1'b0}};
            card_out_rdy = 1'b0;
            busy         = 1'b0;
        end else begin
            card_out     = out_card_q;
            card_src     = out_src_q;
            card_out_rdy = out_rdy_q;
            busy         = (|slot_v_q) || (state_q == ST_EMIT);
        end
    end

endmodule
